console_uart_tx: RTL and testbench

CONSOLE_UART_TX -- requirements
Module: console_uart_tx

---
 rtl/console_pkg.sv | 14 +
 rtl/console_fifo.sv | 54 +++++
 rtl/console_uart_tx.sv | 125 ++++++++++++
 tb/tb_console_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants and FSM encoding for the console UART transmitter.
package console_pkg;

  localparam int unsigned DefaultClksPerBit = 868;  // 100 MHz / 115200
  localparam int unsigned DefaultFifoDepth  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/console_fifo.sv
// First-word-fall-through byte FIFO; dout always shows the head entry when non-empty.
module console_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally since Depth is a power of two; count tells full from empty.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/console_uart_tx.sv
// Buffered 8N1 UART transmitter for the processor console; frames are sent back-to-back.
module console_uart_tx
  import console_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned FIFO_DEPTH   = DefaultFifoDepth
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    CONSOLE_OUT,
  input  logic                          CONSOLE_OUT_valid,
  output logic                          CONSOLE_OUT_ready,
  output logic                          TX,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic       fifo_pop, fifo_full, fifo_empty, baud_last;
  logic [7:0] fifo_dout;

  console_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (CONSOLE_OUT_valid),
    .din_i   (CONSOLE_OUT),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (FIFO_COUNT),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign CONSOLE_OUT_ready = !fifo_full;
  assign BUSY              = (state_q != StIdle) || !fifo_empty;
  assign TX                = tx_q;
  assign baud_last         = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  // tx_d always carries the line level of the state being entered, so TX stays registered.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    if (state_q != StIdle) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = StStart;
          baud_d   = '0;
          tx_d     = 1'b0;
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d   = StData;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      StData: begin
        if (baud_last) begin
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baud_last) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = StStart;
            tx_d     = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: cycle-level frame model plus line receivers, small and default params.
module tb_console_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;
  localparam int unsigned CPB2  = 868;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cvalid, cready, tx, busy;
  logic [7:0] cout;
  logic [2:0] fcount;

  logic       rst2_n, cvalid2, cready2, tx2, busy2;
  logic [7:0] cout2;
  logic [3:0] fcount2;

  console_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK               (clk),
    .RESET             (rst_n),
    .CONSOLE_OUT       (cout),
    .CONSOLE_OUT_valid (cvalid),
    .CONSOLE_OUT_ready (cready),
    .TX                (tx),
    .BUSY              (busy),
    .FIFO_COUNT        (fcount)
  );

  console_uart_tx dut2 (
    .CLK               (clk),
    .RESET             (rst2_n),
    .CONSOLE_OUT       (cout2),
    .CONSOLE_OUT_valid (cvalid2),
    .CONSOLE_OUT_ready (cready2),
    .TX                (tx2),
    .BUSY              (busy2),
    .FIFO_COUNT        (fcount2)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: queue of buffered bytes, byte on the line, cycles left in its frame.
  logic [7:0] q[$];
  logic [7:0] done_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] cur = 8'h00;
  int         rem = 0;
  bit         last_acc = 1'b0;
  bit         rx_on = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_b = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (rem == 0) return 1'b1;
    idx = (FRAME - rem) / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return cur[idx-1];
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit acc, pop;
    int k;
    rst_n  = r;
    cvalid = v;
    cout   = d;
    acc = r && v && (q.size() < DEPTH);
    pop = r && (q.size() > 0) && (rem <= 1);
    if (r && rem == 1) done_q.push_back(cur);
    @(posedge clk);
    if (!r) begin
      q.delete();
      rem = 0;
    end else begin
      if (pop) begin
        cur = q.pop_front();
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (acc) q.push_back(d);
    end
    last_acc = acc;
    #1;
    chk("tx", tx, exp_tx());
    chk("ready", cready, q.size() < DEPTH);
    chk("count", fcount, q.size());
    chk("busy", busy, (q.size() > 0) || (rem > 0));
    // Independent line receiver, sampling mid-bit.
    if (!r) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_t  = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2) begin
        k = rx_t / CPB;
        if (k >= 1 && k <= 8) rx_b[k-1] = tx;
        else if (k == 9) begin
          chk("rx_stop", tx, 1);
          rx_q.push_back(rx_b);
          rx_on = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    string      s;
    int         i, guard, t;
    logic [7:0] b;

    rst2_n = 1'b0; cvalid2 = 1'b0; cout2 = 8'h00;

    // Reset with valid high must not enqueue.
    repeat (3) step(1'b1, 8'hAA, 1'b0);
    idle(2);

    // Single byte 'A'.
    step(1'b1, 8'h41, 1'b1);
    idle(FRAME + 5);

    // Burst "CG3207" holding valid; next char offered only after acceptance.
    s = "CG3207";
    i = 0;
    guard = 0;
    while (i < 6 && guard < 1000) begin
      step(1'b1, s[i], 1'b1);
      if (last_acc) i++;
      guard++;
    end
    chk("burst_accepted", i, 6);
    idle(6 * FRAME + 10);

    // Full boundary: fill, then hold 8'hFF until it is taken.
    guard = 0;
    while (q.size() < DEPTH && guard < 100) begin
      step(1'b1, 8'($urandom), 1'b1);
      guard++;
    end
    chk("filled", q.size(), DEPTH);
    guard = 0;
    last_acc = 1'b0;
    while (!last_acc && guard < 200) begin
      step(1'b1, 8'hFF, 1'b1);
      guard++;
    end
    chk("ff_taken", last_acc, 1);
    idle(DEPTH * FRAME + 2 * FRAME);

    // Push on the STOP->START pop edge with two bytes queued.
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    guard = 0;
    while (rem != 1 && guard < 100) begin
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    chk("pre_simul_count", fcount, 2);
    step(1'b1, 8'h44, 1'b1);
    chk("simul_count", fcount, 2);
    idle(4 * FRAME);

    // Reset during data bit 3 of 8'h0D with two bytes queued.
    step(1'b1, 8'h0D, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'hA5, 1'b1);
    guard = 0;
    while (!(cur == 8'h0D && rem == FRAME - 4 * CPB - 1) && guard < 100) begin
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    chk("mid_frame_reached", rem, FRAME - 4 * CPB - 1);
    step(1'b1, 8'h77, 1'b0);
    chk("rst_tx", tx, 1);
    chk("rst_count", fcount, 0);
    idle(FRAME + 10);
    step(1'b1, 8'h50, 1'b1);
    idle(FRAME + 5);

    // Random traffic.
    for (int n = 0; n < 300; n++) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    idle(DEPTH * FRAME + 2 * FRAME);

    // Everything that completed on the line must decode in order.
    chk("rx_count", rx_q.size(), done_q.size());
    for (int n = 0; n < done_q.size() && n < rx_q.size(); n++) chk("rx_byte", rx_q[n], done_q[n]);

    // Default parameters: 8'h0D frame length and contents.
    @(posedge clk); #1;
    rst2_n = 1'b1;
    @(posedge clk); #1;
    chk("d2_ready", cready2, 1);
    chk("d2_count", fcount2, 0);
    cvalid2 = 1'b1;
    cout2   = 8'h0D;
    @(posedge clk); #1;
    cvalid2 = 1'b0;
    chk("d2_count_push", fcount2, 1);
    guard = 0;
    while (tx2 !== 1'b0 && guard < 5) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("d2_start_latency", guard, 1);
    t = 0;
    b = 8'h00;
    while (busy2 === 1'b1 && t < 20000) begin
      @(posedge clk); #1;
      t++;
      if (t % CPB2 == CPB2 / 2 && t / CPB2 >= 1 && t / CPB2 <= 8) b[t/CPB2-1] = tx2;
      if (t == 9 * CPB2 + CPB2 / 2) chk("d2_stop", tx2, 1);
    end
    chk("d2_frame_len", t, 10 * CPB2);
    chk("d2_byte", b, 8'h0D);
    chk("d2_idle_tx", tx2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
